// File: rtl/mult_div_unit_pkg.sv
// Shared types for the E-stage multiply/divide unit.
// Operation codes, FSM state encoding and a small decode helper.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE   = 2'b00,
    MDU_MUL    = 2'b01,
    MDU_DIV_ST = 2'b10
  } mdu_state_e;

  function automatic logic is_div(input mdu_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/mult_div_unit_compute.sv
// Single-shot arithmetic for the multiply/divide unit.
// Produces the next {HI,LO} from latched operands and current HI/LO.
import mult_div_unit_pkg::*;

module md_compute (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  mdu_op_e     op,
  input  logic        madd,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic        div_zero,
  output logic [31:0] hi_nxt,
  output logic [31:0] lo_nxt
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] acc;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] bs_safe;
  logic [31:0] bu_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;

  assign acc    = {hi, lo};
  assign prod_s = $signed({{32{a[31]}}, a})
                * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide on magnitudes: truncates toward zero and keeps
  // 0x80000000 / -1 well defined as 0x80000000 rem 0.
  assign a_neg   = a[31];
  assign b_neg   = b[31];
  assign a_mag   = a_neg ? (32'd0 - a) : a;
  assign b_mag   = b_neg ? (32'd0 - b) : b;
  assign bs_safe = div_zero ? 32'd1 : b_mag;
  assign bu_safe = div_zero ? 32'd1 : b;
  assign q_mag   = a_mag / bs_safe;
  assign r_mag   = a_mag % bs_safe;
  assign q_s     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign r_s     = a_neg ? (32'd0 - r_mag) : r_mag;
  assign q_u     = a / bu_safe;
  assign r_u     = a % bu_safe;

  always_comb begin
    hi_nxt = hi;
    lo_nxt = lo;
    unique case (1'b1)
      (op == MDU_MULT): begin
        {hi_nxt, lo_nxt} = madd ? (acc + prod_s) : prod_s;
      end
      (op == MDU_MULTU): begin
        {hi_nxt, lo_nxt} = madd ? (acc + prod_u) : prod_u;
      end
      (op == MDU_DIV): begin
        if (!div_zero) begin
          hi_nxt = r_s;
          lo_nxt = q_s;
        end
      end
      (op == MDU_DIVU): begin
        if (!div_zero) begin
          hi_nxt = r_u;
          lo_nxt = q_u;
        end
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with HI/LO registers.
// Counter-driven FSM models multi-cycle latency around md_compute.
import mult_div_unit_pkg::*;

module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        START,
  input  logic [1:0]  MDU_OP,
  input  logic        madd,
  input  logic        WRITE_ENABLED,
  input  logic        HiLo,
  input  logic [31:0] SRC_A,
  input  logic [31:0] SRC_B,
  output logic        BUSY,
  output logic [31:0] HI_LO_OUT
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES)
                      ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  mdu_state_e  state;
  logic [CW-1:0] count;
  logic [CW-1:0] last_cnt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  mdu_op_e     op_q;
  logic        madd_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] hi_nxt;
  logic [31:0] lo_nxt;
  logic        div_zero;

  assign div_zero = (b_q == 32'd0);
  assign last_cnt = (state == MDU_MUL) ? CW'(MULT_CYCLES - 1)
                                       : CW'(DIV_CYCLES - 1);

  md_compute u_compute (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .madd     (madd_q),
    .hi       (hi_q),
    .lo       (lo_q),
    .div_zero (div_zero),
    .hi_nxt   (hi_nxt),
    .lo_nxt   (lo_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MDU_IDLE;
      count  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= MDU_MULT;
      madd_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      unique case (state)
        MDU_IDLE: begin
          // A launch takes priority over a same-cycle mthi/mtlo.
          if (START) begin
            a_q    <= SRC_A;
            b_q    <= SRC_B;
            op_q   <= mdu_op_e'(MDU_OP);
            madd_q <= madd;
            count  <= '0;
            state  <= is_div(mdu_op_e'(MDU_OP)) ? MDU_DIV_ST
                                                : MDU_MUL;
          end else if (WRITE_ENABLED) begin
            if (HiLo) hi_q <= SRC_A;
            else      lo_q <= SRC_A;
          end
        end
        MDU_MUL, MDU_DIV_ST: begin
          if (count == last_cnt) begin
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
            state <= MDU_IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

  assign BUSY      = (state != MDU_IDLE);
  assign HI_LO_OUT = HiLo ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus queues expectations,
// a negedge monitor checks BUSY lengths and HI/LO reads.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        START;
  logic [1:0]  MDU_OP;
  logic        madd;
  logic        WRITE_ENABLED;
  logic        HiLo;
  logic [31:0] SRC_A;
  logic [31:0] SRC_B;
  logic        BUSY;
  logic [31:0] HI_LO_OUT;

  logic        rd = 1'b0;
  logic [31:0] exp_rd_q[$];
  int          exp_busy_q[$];
  int          busy_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk           (clk),
    .reset         (reset),
    .START         (START),
    .MDU_OP        (MDU_OP),
    .madd          (madd),
    .WRITE_ENABLED (WRITE_ENABLED),
    .HiLo          (HiLo),
    .SRC_A         (SRC_A),
    .SRC_B         (SRC_B),
    .BUSY          (BUSY),
    .HI_LO_OUT     (HI_LO_OUT)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [31:0] e;
    int          eb;
    if (rd) begin
      checks++;
      if (exp_rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got %h", HI_LO_OUT);
      end else begin
        e = exp_rd_q.pop_front();
        if (HI_LO_OUT !== e) begin
          errors++;
          $display("FAIL rd_%s got %h want %h",
                   HiLo ? "hi" : "lo", HI_LO_OUT, e);
        end
      end
    end
    if (BUSY === 1'b1) begin
      busy_cnt++;
    end else if (busy_cnt > 0) begin
      checks++;
      if (exp_busy_q.size() == 0) begin
        errors++;
        $display("FAIL busy_unexpected got %0d want none", busy_cnt);
      end else begin
        eb = exp_busy_q.pop_front();
        if (busy_cnt != eb) begin
          errors++;
          $display("FAIL busy_len got %0d want %0d", busy_cnt, eb);
        end
      end
      busy_cnt = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic read(input logic h, input logic [31:0] v);
    HiLo = h;
    rd   = 1'b1;
    exp_rd_q.push_back(v);
    cyc();
    rd = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY !== 1'b0 && n < 64) begin
      cyc();
      n++;
    end
    if (BUSY !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout got %b want 0", BUSY);
    end
  endtask

  task automatic launch(input logic [1:0] op, input logic m,
                        input logic [31:0] a, input logic [31:0] b);
    MDU_OP = op;
    madd   = m;
    SRC_A  = a;
    SRC_B  = b;
    START  = 1'b1;
    cyc();
    START  = 1'b0;
    madd   = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic m,
                        input logic [31:0] a, input logic [31:0] b,
                        input int blen,
                        input logic [31:0] ehi, input logic [31:0] elo);
    exp_busy_q.push_back(blen);
    launch(op, m, a, b);
    wait_idle();
    read(1'b1, ehi);
    read(1'b0, elo);
  endtask

  task automatic write_reg(input logic h, input logic [31:0] v);
    HiLo          = h;
    SRC_A         = v;
    WRITE_ENABLED = 1'b1;
    cyc();
    WRITE_ENABLED = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    START = 1'b0;
    MDU_OP = 2'b00;
    madd = 1'b0;
    WRITE_ENABLED = 1'b0;
    HiLo = 1'b0;
    SRC_A = '0;
    SRC_B = '0;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", BUSY);
    end
    read(1'b1, 32'h0);
    read(1'b0, 32'h0);

    run_op(2'b00, 1'b0, 32'hFFFF_FFFF, 32'h2, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(2'b01, 1'b0, 32'hFFFF_FFFF, 32'h2, 5,
           32'h0000_0001, 32'hFFFF_FFFE);
    run_op(2'b10, 1'b0, 32'hFFFF_FFF9, 32'h2, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(2'b11, 1'b0, 32'h7, 32'h0, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(2'b10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 10,
           32'h0, 32'h8000_0000);
    run_op(2'b11, 1'b0, 32'hFFFF_FFF9, 32'h2, 10,
           32'h1, 32'h7FFF_FFFC);
    run_op(2'b10, 1'b1, 32'd100, 32'd7, 10,
           32'd2, 32'd14);

    write_reg(1'b0, 32'h1234_5678);
    read(1'b0, 32'h1234_5678);
    write_reg(1'b1, 32'h1);
    read(1'b1, 32'h1);
    read(1'b0, 32'h1234_5678);
    run_op(2'b00, 1'b1, 32'h0001_0000, 32'h0001_0000, 5,
           32'h2, 32'h1234_5678);
    run_op(2'b00, 1'b1, 32'hFFFF_FFFF, 32'h1, 5,
           32'h2, 32'h1234_5677);

    exp_busy_q.push_back(5);
    launch(2'b00, 1'b0, 32'd3, 32'd4);
    cyc();
    MDU_OP = 2'b10;
    SRC_A = 32'hDEAD_BEEF;
    SRC_B = 32'h1;
    HiLo = 1'b1;
    START = 1'b1;
    WRITE_ENABLED = 1'b1;
    cyc();
    START = 1'b0;
    WRITE_ENABLED = 1'b0;
    wait_idle();
    read(1'b1, 32'h0);
    read(1'b0, 32'hC);

    exp_busy_q.push_back(5);
    HiLo = 1'b1;
    WRITE_ENABLED = 1'b1;
    launch(2'b01, 1'b1, 32'd5, 32'd6);
    WRITE_ENABLED = 1'b0;
    wait_idle();
    read(1'b1, 32'h0);
    read(1'b0, 32'h2A);

    exp_busy_q.push_back(3);
    launch(2'b10, 1'b0, 32'd100, 32'd7);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy got %b want 0", BUSY);
    end
    read(1'b1, 32'h0);
    read(1'b0, 32'h0);
    run_op(2'b00, 1'b0, 32'd7, 32'hFFFF_FFFD, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFEB);

    repeat (3) cyc();
    checks++;
    if (exp_busy_q.size() != 0 || exp_rd_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d/%0d want 0/0",
               exp_busy_q.size(), exp_rd_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
